// File: rtl/clk_gate_ctrl.sv
// Clock-demand scheduler for one gated clock domain: arbitrates requesters and a software
// force-on, sequences the gating cell's active/bypass inputs and grants requesters once clocked.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 3,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  input  logic               bypass_cfg,
  output logic               active,
  output logic               bypass,
  output logic [NUM_REQ-1:0] ack,
  output logic [1:0]         state_o,
  output logic [15:0]        wake_count
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             demand;
  logic             turn_on;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign demand  = (|req) | force_on;
  assign state_o = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    turn_on   = 1'b0;
    case (state)
      S_OFF: begin
        if (demand) begin
          turn_on = 1'b1;
          // With bypass requested the clock is already free-running, so no wake-up wait.
          if (bypass_cfg) begin
            state_nxt = S_ON;
          end else begin
            state_nxt = S_WAKE;
            cnt_nxt   = CNT_W'(WAKE_CYCLES);
          end
        end
      end
      S_WAKE: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = S_ON;
      end
      S_ON: begin
        if (!demand) begin
          state_nxt = S_IDLE;
          cnt_nxt   = CNT_W'(IDLE_CYCLES);
        end
      end
      S_IDLE: begin
        // Demand returning during the idle hold, even on its last cycle, keeps the clock on.
        if (demand) begin
          state_nxt = S_ON;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      cnt        <= '0;
      active     <= 1'b0;
      bypass     <= 1'b0;
      ack        <= '0;
      wake_count <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      active <= (state_nxt != S_OFF);
      bypass <= bypass_cfg;
      ack    <= (state_nxt == S_ON) ? req : '0;
      if (turn_on) wake_count <= sat_inc(wake_count);
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: per-scenario tasks push expected outputs to a scoreboard queue
// and pop/compare them after each clock edge.
module tb_clk_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        force_on;
  logic        bypass_cfg;
  logic        active;
  logic        bypass;
  logic [3:0]  ack;
  logic [1:0]  state_o;
  logic [15:0] wake_count;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    string       nm;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sbq[$];

  localparam int SEL_ACT = 0, SEL_BYP = 1, SEL_ACK = 2, SEL_ST = 3, SEL_WC = 4;

  clk_gate_ctrl #(
    .NUM_REQ(4), .WAKE_CYCLES(3), .IDLE_CYCLES(16), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .force_on(force_on), .bypass_cfg(bypass_cfg),
    .active(active), .bypass(bypass), .ack(ack), .state_o(state_o), .wake_count(wake_count)
  );

  always #5 clk = ~clk;

  function automatic void push(input string nm, input int sel, input logic [15:0] v);
    exp_t e;
    e.nm  = nm;
    e.sel = sel;
    e.val = v;
    sbq.push_back(e);
  endfunction

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_ACT: return {15'd0, active};
      SEL_BYP: return {15'd0, bypass};
      SEL_ACK: return {12'd0, ack};
      SEL_ST:  return {14'd0, state_o};
      default: return wake_count;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] o;
    rst = 1'b1; req = 4'hF; force_on = 1'b0; bypass_cfg = 1'b0;
    tick();
    tick();
    push("rst_active", SEL_ACT, 16'd0);
    push("rst_ack",    SEL_ACK, 16'd0);
    push("rst_state",  SEL_ST,  16'd0);
    push("rst_wcount", SEL_WC,  16'd0);
    push("rst_bypass", SEL_BYP, 16'd0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); nchk++;
      if (o !== e.val) begin nerr++; $display("FAIL %s: got %0h expected %0h", e.nm, o, e.val); end
    end
    rst = 1'b0; req = 4'h0;
    tick();
  endtask

  // req at T: active at T+1, WAKE for 3 cycles, ack at T+4
  task automatic test_wake(input logic [3:0] r, input logic [15:0] wc_exp);
    exp_t e;
    logic [15:0] o;
    req = r;
    for (int k = 1; k <= 4; k++) begin
      tick();
      push("wake_active", SEL_ACT, 16'd1);
      push("wake_state",  SEL_ST,  (k < 4) ? 16'd1 : 16'd2);
      push("wake_ack",    SEL_ACK, (k < 4) ? 16'd0 : {12'd0, r});
      push("wake_wcount", SEL_WC,  wc_exp);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); o = observe(e.sel); nchk++;
        if (o !== e.val) begin nerr++; $display("FAIL %s(k=%0d): got %0h expected %0h", e.nm, k, o, e.val); end
      end
    end
  endtask

  // drop demand, then active must fall exactly 16 cycles after IDLE_WAIT entry
  task automatic test_idle();
    exp_t e;
    logic [15:0] o;
    req = 4'h0; force_on = 1'b0;
    tick();
    push("idle_ack",   SEL_ACK, 16'd0);
    push("idle_state", SEL_ST,  16'd3);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick();
      push("idle_active", SEL_ACT, (k < 16) ? 16'd1 : 16'd0);
      push("idle_state",  SEL_ST,  (k < 16) ? 16'd3 : 16'd0);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); o = observe(e.sel); nchk++;
        if (o !== e.val) begin nerr++; $display("FAIL %s(k=%0d): got %0h expected %0h", e.nm, k, o, e.val); end
      end
      if (k == 1) tick();
    end
  endtask

  task automatic test_revive();
    exp_t e;
    logic [15:0] o;
    test_wake(4'b0001, 16'd2);
    req = 4'h0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      push("rev_hold_active", SEL_ACT, 16'd1);
      push("rev_hold_state",  SEL_ST,  16'd3);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); o = observe(e.sel); nchk++;
        if (o !== e.val) begin nerr++; $display("FAIL %s(k=%0d): got %0h expected %0h", e.nm, k, o, e.val); end
      end
      // entry plus 15 decrements puts us on the last IDLE_WAIT cycle
      if (k == 16) req = 4'b0100;
    end
    tick();
    push("rev_state",  SEL_ST,  16'd2);
    push("rev_active", SEL_ACT, 16'd1);
    push("rev_ack",    SEL_ACK, 16'b0100);
    push("rev_wcount", SEL_WC,  16'd2);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); o = observe(e.sel); nchk++;
      if (o !== e.val) begin nerr++; $display("FAIL %s: got %0h expected %0h", e.nm, o, e.val); end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [15:0] o;
    req = 4'h0;
    repeat (17) tick();
    bypass_cfg = 1'b1;
    tick();
    push("byp_reg",       SEL_BYP, 16'd1);
    push("byp_state_off", SEL_ST,  16'd0);
    push("byp_active0",   SEL_ACT, 16'd0);
    for (int k = 0; k < 3; k++) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); o = observe(e.sel); nchk++;
        if (o !== e.val) begin nerr++; $display("FAIL %s(k=%0d): got %0h expected %0h", e.nm, k, o, e.val); end
      end
      if (k == 0) begin
        req = 4'b1000;
        tick();
        push("byp_state",  SEL_ST,  16'd2);
        push("byp_active", SEL_ACT, 16'd1);
        push("byp_ack",    SEL_ACK, 16'b1000);
        push("byp_wcount", SEL_WC,  16'd3);
      end else if (k == 1) begin
        req = 4'h0; force_on = 1'b1;
        tick();
        push("force_state",  SEL_ST,  16'd2);
        push("force_active", SEL_ACT, 16'd1);
        push("force_noack",  SEL_ACK, 16'd0);
      end
    end
    force_on = 1'b0; bypass_cfg = 1'b0;
    repeat (17) tick();
  endtask

  task automatic test_midreset_sat();
    exp_t e;
    logic [15:0] o;
    req = 4'b0001;
    tick();
    push("mr_pre_state", SEL_ST, 16'd1);
    push("mr_pre_wc",    SEL_WC, 16'd4);
    for (int k = 0; k < 4; k++) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); o = observe(e.sel); nchk++;
        if (o !== e.val) begin nerr++; $display("FAIL %s(k=%0d): got %0h expected %0h", e.nm, k, o, e.val); end
      end
      if (k == 0) begin
        rst = 1'b1;
        tick();
        push("mr_state",  SEL_ST,  16'd0);
        push("mr_active", SEL_ACT, 16'd0);
        push("mr_ack",    SEL_ACK, 16'd0);
        push("mr_wc",     SEL_WC,  16'd0);
      end else if (k == 1) begin
        rst = 1'b0; req = 4'h0;
        tick();
        force dut.wake_count = 16'hFFFF;
        #1;
        release dut.wake_count;
        push("sat_preload", SEL_WC, 16'hFFFF);
      end else if (k == 2) begin
        force_on = 1'b1;
        tick();
        push("sat_state", SEL_ST, 16'd1);
        push("sat_wc",    SEL_WC, 16'hFFFF);
      end
    end
    force_on = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'h0; force_on = 1'b0; bypass_cfg = 1'b0;
    @(negedge clk);
    test_reset();
    test_wake(4'b0001, 16'd1);
    test_idle();
    test_revive();
    test_bypass();
    test_midreset_sat();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
